// File: rtl/tcam_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcam_sched_pkg                                                           |
// | Shared types and helpers for the TCAM RAM read scheduler.                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package tcam_sched_pkg;

  localparam int c_ID_W = 3;

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic              valid;
    logic [c_ID_W-1:0] id;
    logic              fwd;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/tcam_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcam_rr_pick2                                                            |
// | Two-grant round-robin picker: first eligible at/after the pointer gets   |
// | port B, the next one gets port C.                                        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tcam_rr_pick2
  import tcam_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = calc_addr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_b,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [PTR_W-1:0]   o_next_ptr
);

  logic w_have_b;
  logic w_have_c;

  // Pass 0 scans indices >= pointer, pass 1 wraps around to those below it.
  always_comb begin
    o_gnt_b    = '0;
    o_gnt_c    = '0;
    o_next_ptr = i_ptr;
    w_have_b   = 1'b0;
    w_have_c   = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i_elig[j] && ((pass == 0) == (j >= int'(i_ptr)))) begin
          if (!w_have_b) begin
            o_gnt_b[j] = 1'b1;
            w_have_b   = 1'b1;
            o_next_ptr = PTR_W'((j + 1) % NUM_REQ);
          end else if (!w_have_c) begin
            o_gnt_c[j] = 1'b1;
            w_have_c   = 1'b1;
            o_next_ptr = PTR_W'((j + 1) % NUM_REQ);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcam_ram_rd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcam_ram_rd_sched                                                        |
// | Clears the TCAM RAM, passes table writes and shares its two read ports   |
// | among NUM_REQ lookup clients. Optional macro: TCAM_SCHED_FWD_EN          |
// | (forward same-cycle write data instead of stalling the read).            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tcam_ram_rd_sched
  import tcam_sched_pkg::*;
#(
  parameter int                   NUM_REQ    = 4,
  parameter int                   RAM_WIDTH  = 32,
  parameter int                   RAM_DEPTH  = 16,
  parameter int                   RD_LATENCY = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VAL   = '0,
  localparam int                  ADDR_W     = calc_addr_w(RAM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_req,
  output logic                           init_done,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [RAM_WIDTH-1:0]           wr_data,
  input  logic [NUM_REQ-1:0]             rd_req,
  output logic [NUM_REQ-1:0]             rd_gnt,
  input  logic [NUM_REQ*ADDR_W-1:0]      rd_addr,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*RAM_WIDTH-1:0]   rsp_data,
  output logic                           ram_wea,
  output logic [ADDR_W-1:0]              ram_addra,
  output logic [RAM_WIDTH-1:0]           ram_dina,
  output logic                           ram_enb,
  output logic [ADDR_W-1:0]              ram_addrb,
  output logic                           ram_enc,
  output logic [ADDR_W-1:0]              ram_addrc,
  output logic                           ram_regce,
  output logic                           ram_rst,
  input  logic [RAM_WIDTH-1:0]           ram_doutb,
  input  logic [RAM_WIDTH-1:0]           ram_doutc
);

  localparam int                PTR_W  = calc_addr_w(NUM_REQ);
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(RAM_DEPTH - 1);

  sched_state_t           r_state;
  logic                   r_clr_we;
  logic [ADDR_W-1:0]      r_clr_addr;
  logic                   r_run;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       w_next_ptr;
  logic                   w_wr_fire;
  logic [NUM_REQ-1:0]     w_conflict;
  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_gnt_b;
  logic [NUM_REQ-1:0]     w_gnt_c;
  logic                   w_fwd_b;
  logic                   w_fwd_c;
  logic [ADDR_W-1:0]      w_addr_b;
  logic [ADDR_W-1:0]      w_addr_c;
  logic [c_ID_W-1:0]      w_id_b;
  logic [c_ID_W-1:0]      w_id_c;
  rsp_tag_t               w_tag_b;
  rsp_tag_t               w_tag_c;
  rsp_tag_t               r_pipe_b [RD_LATENCY];
  rsp_tag_t               r_pipe_c [RD_LATENCY];
  logic [RAM_WIDTH-1:0]   r_wdat   [RD_LATENCY];
  rsp_tag_t               w_out_b;
  rsp_tag_t               w_out_c;
  logic [RAM_WIDTH-1:0]   w_data_b;
  logic [RAM_WIDTH-1:0]   w_data_c;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [NUM_REQ*RAM_WIDTH-1:0] r_rsp_data;

  // Clear sweep: r_clr_we/r_clr_addr are the registered write-port values,
  // so the first clear write lands one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_clr_we   <= 1'b0;
      r_clr_addr <= '0;
      r_run      <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (!r_clr_we || clr_req) begin
            r_clr_we   <= 1'b1;
            r_clr_addr <= '0;
          end else if (r_clr_addr == c_LAST) begin
            r_state  <= ST_RUN;
            r_clr_we <= 1'b0;
            r_run    <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            r_state    <= ST_INIT;
            r_clr_we   <= 1'b1;
            r_clr_addr <= '0;
            r_run      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign init_done = r_run;
  assign wr_ready  = r_run;
  assign w_wr_fire = wr_valid & r_run;

  assign ram_wea   = r_clr_we | w_wr_fire;
  assign ram_addra = r_clr_we ? r_clr_addr : (w_wr_fire ? wr_addr : '0);
  assign ram_dina  = r_clr_we ? INIT_VAL   : (w_wr_fire ? wr_data : '0);
  assign ram_regce = 1'b1;
  assign ram_rst   = 1'b0;

  for (genvar j = 0; j < NUM_REQ; j++) begin : g_conflict
    assign w_conflict[j] = w_wr_fire && (rd_addr[j*ADDR_W +: ADDR_W] == wr_addr);
  end

`ifdef TCAM_SCHED_FWD_EN
  assign w_elig  = rd_req & {NUM_REQ{r_run}};
  assign w_fwd_b = |(w_gnt_b & w_conflict);
  assign w_fwd_c = |(w_gnt_c & w_conflict);
`else
  assign w_elig  = rd_req & {NUM_REQ{r_run}} & ~w_conflict;
  assign w_fwd_b = 1'b0;
  assign w_fwd_c = 1'b0;
`endif

  tcam_rr_pick2 #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_elig     (w_elig),
    .i_ptr      (r_rr_ptr),
    .o_gnt_b    (w_gnt_b),
    .o_gnt_c    (w_gnt_c),
    .o_next_ptr (w_next_ptr)
  );

  assign rd_gnt = w_gnt_b | w_gnt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rr_ptr <= '0;
    else        r_rr_ptr <= w_next_ptr;
  end

  always_comb begin
    w_addr_b = '0;
    w_addr_c = '0;
    w_id_b   = '0;
    w_id_c   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt_b[j]) begin
        w_addr_b = rd_addr[j*ADDR_W +: ADDR_W];
        w_id_b   = c_ID_W'(j);
      end
      if (w_gnt_c[j]) begin
        w_addr_c = rd_addr[j*ADDR_W +: ADDR_W];
        w_id_c   = c_ID_W'(j);
      end
    end
  end

  assign ram_enb   = |w_gnt_b;
  assign ram_enc   = |w_gnt_c;
  assign ram_addrb = w_addr_b;
  assign ram_addrc = w_addr_c;

  assign w_tag_b = '{valid: ram_enb, id: w_id_b, fwd: w_fwd_b};
  assign w_tag_c = '{valid: ram_enc, id: w_id_c, fwd: w_fwd_c};

  // Tag pipelines track the RAM read latency so the tag exits with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_b[i] <= '0;
        r_pipe_c[i] <= '0;
        r_wdat[i]   <= '0;
      end
    end else begin
      r_pipe_b[0] <= w_tag_b;
      r_pipe_c[0] <= w_tag_c;
      r_wdat[0]   <= wr_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_b[i] <= r_pipe_b[i-1];
        r_pipe_c[i] <= r_pipe_c[i-1];
        r_wdat[i]   <= r_wdat[i-1];
      end
    end
  end

  assign w_out_b  = r_pipe_b[RD_LATENCY-1];
  assign w_out_c  = r_pipe_c[RD_LATENCY-1];
  assign w_data_b = w_out_b.fwd ? r_wdat[RD_LATENCY-1] : ram_doutb;
  assign w_data_c = w_out_c.fwd ? r_wdat[RD_LATENCY-1] : ram_doutc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_out_b.valid && (w_out_b.id == c_ID_W'(j))) begin
          r_rsp_valid[j]                       <= 1'b1;
          r_rsp_data[j*RAM_WIDTH +: RAM_WIDTH] <= w_data_b;
        end
        if (w_out_c.valid && (w_out_c.id == c_ID_W'(j))) begin
          r_rsp_valid[j]                       <= 1'b1;
          r_rsp_data[j*RAM_WIDTH +: RAM_WIDTH] <= w_data_c;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: doc/tcam_ram_rd_sched.md
Name: tcam_ram_rd_sched

Overview:
- Scheduler/controller in front of the TCAM dual-read-port simple-dual-port RAM (1 write port A, 2 read ports B/C).
- Clears the table after reset or on request, accepts table writes, and round-robin shares the two read channels among NUM_REQ lookup clients.
- Routes each read result back to the requester that issued it, with a fixed latency.
- Sits between the TCAM match engines and the RAM instance.

Parameters:
- NUM_REQ, 4, number of lookup requesters (2..8).
- RAM_WIDTH, 32, RAM data width.
- RAM_DEPTH, 16, RAM entries; ADDR_W = clog2(RAM_DEPTH), minimum 1.
- RD_LATENCY, 1, RAM read latency in cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE.
- INIT_VAL, 0, value written to every entry during clear.

Ports:
- clk  in  1  single clock for the block and the RAM (clka=clkb=clkc)
- rst_n  in  1  asynchronous active-low reset
- clr_req  in  1  pulse: re-clear the whole table
- init_done  out  1  high when in RUN state
- wr_valid  in  1  table write request
- wr_ready  out  1  write accepted when valid&ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  RAM_WIDTH  write data
- rd_req  in  NUM_REQ  per-requester read request
- rd_gnt  out  NUM_REQ  per-requester grant (combinational, same cycle)
- rd_addr  in  NUM_REQ*ADDR_W  flattened read addresses
- rsp_valid  out  NUM_REQ  per-requester response strobe
- rsp_data  out  NUM_REQ*RAM_WIDTH  flattened response data
- ram_wea, ram_addra, ram_dina  out  1/ADDR_W/RAM_WIDTH  RAM write port
- ram_enb, ram_addrb, ram_enc, ram_addrc  out  1/ADDR_W/1/ADDR_W  RAM read ports
- ram_regce  out  1  tied 1 (drives regceb and regcec)
- ram_rst  out  1  tied 0 (drives rstb and rstc)
- ram_doutb, ram_doutc  in  RAM_WIDTH  RAM read data

Behaviour:
- Reset values: init_done=0, wr_ready=0, rd_gnt=0, rsp_valid=0, rsp_data=0, ram_wea=0, ram_enb=ram_enc=0, address outputs 0, rr_ptr=0, FSM=INIT, init_addr=0.
- FSM INIT:
  - ram_wea=1, ram_addra=init_addr, ram_dina=INIT_VAL each cycle; init_addr increments.
  - Move to RUN after writing address RAM_DEPTH-1; the clear takes exactly RAM_DEPTH cycles.
  - wr_ready=0 and rd_gnt=0 throughout.
- FSM RUN:
  - init_done=1; wr_ready=1; each write takes one cycle and drives the RAM write port combinationally from wr_*.
  - clr_req in RUN → INIT next cycle with init_addr=0.
  - clr_req during INIT restarts the clear from address 0.
- Read arbitration (RUN only):
  - Among eligible requesters, the first at or after rr_ptr (cyclic) is granted port B; the next eligible after it is granted port C.
  - Each requester gets at most one grant per cycle.
  - rr_ptr ← (index of last grant + 1) mod NUM_REQ; rr_ptr holds if nothing is granted.
  - Eligible = rd_req set AND NOT (wr_valid & wr_ready & rd_addr==wr_addr). A same-cycle same-address read is stalled one cycle, so every granted read returns committed data.
  - Requester keeps rd_req and rd_addr stable until granted.
- Response path:
  - Per port, a RD_LATENCY-deep pipeline carries {valid, requester id}.
  - At the pipeline output: rsp_valid[id]=1 and rsp_data[id] = the port's dout, registered. Total grant→rsp_valid latency = RD_LATENCY+1 cycles.
  - Ports B and C never target the same id in one cycle, so there are no collisions.
  - rsp_data holds its last value when rsp_valid=0.
- Clear mid-operation: in-flight reads still complete and deliver their data; no new grants until init_done.
- Async reset mid-operation: pipelines are flushed and no responses are issued.

Optional Feature:
- TCAM_SCHED_FWD_EN defined:
  - The same-address write/read conflict is not stalled; the read is granted.
  - The pipeline carries a fwd flag plus wr_data, and the response returns the newly written data.
  - The conflict is therefore invisible to the requester.
- Undefined: stall rule as above.

Decomposition:
- Package tcam_sched_pkg: ADDR_W function (clog2), FSM state encoding (INIT, RUN), response tag struct {valid, id, fwd}.
- One sub-module: tcam_rr_pick2, combinational two-grant round-robin picker (eligible vector + pointer → gnt_b/gnt_c one-hot plus next pointer). Instantiated once.

Test Plan:
- Reset, then RAM_DEPTH=16 → ram_wea high for exactly 16 cycles at addresses 0..15 with data 0, init_done rises in cycle 17; rd_req asserted during INIT is not granted.
- Write addr 3=0xDEADBEEF, then req0 reads addr 3 the next cycle → rsp_valid[0] exactly 2 cycles after grant (RD_LATENCY=1) with data 0xDEADBEEF; with RD_LATENCY=2, 3 cycles.
- All 4 requesters assert continuously, rr_ptr=0 → grants {0→B,1→C}, then {2,3}, then {0,1}; each gets rsp_valid at a 50% rate.
- Write addr 5=0x11 while req2 reads addr 5 in the same cycle → req2 not granted that cycle, granted next, returns 0x11; with TCAM_SCHED_FWD_EN → granted the same cycle, returns 0x11.
- clr_req while 2 reads are in flight → both responses delivered, then 16 clear cycles, then reading addr 3 returns INIT_VAL.
- rst_n low for 1 cycle mid-response → rsp_valid=0 immediately, no stale responses after release.
